// File: rtl/neopix_pkg.sv
// Shared types and timing constants for the WS2812 line driver.
// All cycle counts are floor(ns * clk_hz / 1e9).
package neopix_pkg;

    typedef enum logic [1:0] {
        ST_LATCH,
        ST_LOAD,
        ST_SEND
    } state_t;

    localparam int unsigned T0H_NS    = 400;
    localparam int unsigned T1H_NS    = 800;
    localparam int unsigned TBIT_NS   = 1250;
    localparam int unsigned TLATCH_NS = 60000;

    function automatic int unsigned ns_to_cycles(input int unsigned ns,
                                                 input longint unsigned clk_hz);
        longint unsigned prod;
        prod = longint'(ns) * clk_hz;
        return 32'(prod / 64'd1000000000);
    endfunction

endpackage

// File: rtl/neopix_bit_encoder.sv
// Shifts a 24-bit GRB word out MSB first as WS2812 pulse-width symbols.
// DO is registered; done pulses in the final cycle of bit 23.
module neopix_bit_encoder
    import neopix_pkg::*;
#(
    parameter int unsigned T0H  = 20,
    parameter int unsigned T1H  = 40,
    parameter int unsigned TBIT = 62
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [23:0] rgb,
    output logic        DO,
    output logic        done
);

    localparam int unsigned PW = $clog2(TBIT);

    logic [23:0]   shreg;
    logic [PW-1:0] pcnt;
    logic [4:0]    bcnt;
    logic          active;
    logic          period_end;
    logic          nxt_bit;
    logic [PW-1:0] nxt_p;

    function automatic logic [PW-1:0] high_len(input logic b);
        return b ? PW'(T1H) : PW'(T0H);
    endfunction

    always_comb begin
        period_end = active && (pcnt == PW'(TBIT - 1));
        done       = period_end && (bcnt == 5'd23);
        nxt_p      = period_end ? '0 : pcnt + PW'(1);
        nxt_bit    = period_end ? shreg[22] : shreg[23];
    end

    // DO is computed one cycle ahead from the next counter value so the
    // high phase of every symbol is exactly T0H/T1H cycles long.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg  <= '0;
            pcnt   <= '0;
            bcnt   <= '0;
            active <= 1'b0;
            DO     <= 1'b0;
        end else if (load) begin
            shreg  <= rgb;
            pcnt   <= '0;
            bcnt   <= '0;
            active <= 1'b1;
            DO     <= 1'b1;
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
                DO     <= 1'b0;
            end else begin
                pcnt <= nxt_p;
                if (period_end) begin
                    shreg <= {shreg[22:0], 1'b0};
                    bcnt  <= bcnt + 5'd1;
                end
                DO <= (nxt_p < high_len(nxt_bit));
            end
        end else begin
            DO <= 1'b0;
        end
    end

endmodule

// File: rtl/neopix_tx.sv
// WS2812 chain driver: fetches one LED colour at a time from the upstream
// buffer, serialises it, and inserts the latch gap between frames.
module neopix_tx
    import neopix_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int SYSTEM_CLOCK = 50000000
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        reset_state,
    output logic                        data_request,
    output logic                        new_address,
    output logic [$clog2(NUM_LEDS)-1:0] address,
    input  logic [7:0]                  red_in,
    input  logic [7:0]                  green_in,
    input  logic [7:0]                  blue_in,
    output logic                        DO
);

    localparam int unsigned AW     = $clog2(NUM_LEDS);
    localparam int unsigned T0H    = ns_to_cycles(T0H_NS, 64'(SYSTEM_CLOCK));
    localparam int unsigned T1H    = ns_to_cycles(T1H_NS, 64'(SYSTEM_CLOCK));
    localparam int unsigned TBIT   = ns_to_cycles(TBIT_NS, 64'(SYSTEM_CLOCK));
    localparam int unsigned TLATCH = ns_to_cycles(TLATCH_NS, 64'(SYSTEM_CLOCK));
    localparam int unsigned LW     = $clog2(TLATCH);

    state_t        state;
    logic [LW-1:0] lcnt;
    logic          load_phase;
    logic          last_led;
    logic          enc_load;
    logic          enc_done;
    logic [AW-1:0] addr_next;

    always_comb begin
        enc_load  = (state == ST_LOAD) && load_phase;
        addr_next = (address == AW'(NUM_LEDS - 1)) ? '0 : address + AW'(1);
    end

    neopix_bit_encoder #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_enc (
        .clk   (clk),
        .reset (reset),
        .load  (enc_load),
        .rgb   ({green_in, red_in, blue_in}),
        .DO    (DO),
        .done  (enc_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_LATCH;
            lcnt         <= '0;
            load_phase   <= 1'b0;
            last_led     <= 1'b0;
            address      <= '0;
            reset_state  <= 1'b1;
            data_request <= 1'b0;
            new_address  <= 1'b0;
        end else begin
            data_request <= 1'b0;
            new_address  <= 1'b0;
            case (state)
                ST_LATCH: begin
                    if (lcnt == LW'(TLATCH - 1)) begin
                        lcnt         <= '0;
                        state        <= ST_LOAD;
                        load_phase   <= 1'b0;
                        data_request <= 1'b1;
                        reset_state  <= 1'b0;
                    end else begin
                        lcnt <= lcnt + LW'(1);
                    end
                end
                ST_LOAD: begin
                    // Address advances as the word is captured, giving the
                    // upstream buffer a full LED slot to present the next one.
                    if (load_phase) begin
                        state       <= ST_SEND;
                        load_phase  <= 1'b0;
                        last_led    <= (address == AW'(NUM_LEDS - 1));
                        address     <= addr_next;
                        new_address <= 1'b1;
                    end else begin
                        load_phase <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (enc_done) begin
                        if (last_led) begin
                            state       <= ST_LATCH;
                            reset_state <= 1'b1;
                        end else begin
                            state        <= ST_LOAD;
                            data_request <= 1'b1;
                        end
                    end
                end
                default: state <= ST_LATCH;
            endcase
        end
    end

endmodule

// File: tb/tb_neopix_tx.sv
// Randomised bench for neopix_tx: a default instance and a 2-LED / 100 MHz
// instance share stimulus and are compared every cycle to a frame-position model.
module tb_neopix_tx;

    localparam int unsigned A_N = 8, A_T0 = 20, A_T1 = 40, A_TB = 62,  A_TL = 3000;
    localparam int unsigned B_N = 2, B_T0 = 40, B_T1 = 80, B_TB = 125, B_TL = 6000;
    localparam int unsigned A_SLOT  = 2 + 24 * A_TB;
    localparam int unsigned A_FRAME = A_TL + A_N * A_SLOT;
    localparam int unsigned C_RST   = 2 * A_FRAME + A_TL + 3 * A_SLOT + 2 + 10 * A_TB + 5;
    localparam logic [7:0]  RST_TUPLE = 8'b1000_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] red_in = '0, green_in = '0, blue_in = '0;

    logic       rs_a, dr_a, na_a, do_a;
    logic [2:0] addr_a;
    logic       rs_b, dr_b, na_b, do_b;
    logic [0:0] addr_b;

    always #5 clk = ~clk;

    neopix_tx #(.NUM_LEDS(8), .SYSTEM_CLOCK(50000000)) dut_a (
        .clk(clk), .reset(reset), .reset_state(rs_a), .data_request(dr_a),
        .new_address(na_a), .address(addr_a), .red_in(red_in),
        .green_in(green_in), .blue_in(blue_in), .DO(do_a)
    );

    neopix_tx #(.NUM_LEDS(2), .SYSTEM_CLOCK(100000000)) dut_b (
        .clk(clk), .reset(reset), .reset_state(rs_b), .data_request(dr_b),
        .new_address(na_b), .address(addr_b), .red_in(red_in),
        .green_in(green_in), .blue_in(blue_in), .DO(do_b)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [23:0]  hist [40000];
    int unsigned  c = 0;
    int unsigned  gc = 0;
    int unsigned  epoch = 1;
    int unsigned  hi_run = 0;
    int           first_dr = -1;
    logic         rs_prev = 1'b1;
    int unsigned  pulses[$];
    int unsigned  rises[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected {reset_state, data_request, new_address, DO, address} for
    // cycle cyc after reset release, from the frame/slot/bit arithmetic.
    function automatic logic [7:0] ref_out(input int unsigned cyc, input int unsigned n,
                                           input int unsigned t0h, input int unsigned t1h,
                                           input int unsigned tbit, input int unsigned tlatch);
        int unsigned slot, frame, pos, k, o, b, p, addr;
        logic [23:0] grb;
        logic rs, dr, na, d;
        slot  = 2 + 24 * tbit;
        frame = tlatch + n * slot;
        pos   = cyc % frame;
        rs = 1'b1; dr = 1'b0; na = 1'b0; d = 1'b0; addr = 0;
        if (pos >= tlatch) begin
            k  = (pos - tlatch) / slot;
            o  = (pos - tlatch) % slot;
            rs = 1'b0;
            dr = (o == 0);
            na = (o == 2);
            addr = (o < 2) ? k : (k + 1) % n;
            if (o >= 2) begin
                grb = hist[cyc - o + 1];
                b = (o - 2) / tbit;
                p = (o - 2) % tbit;
                d = (p < (grb[23 - b] ? t1h : t0h));
            end
        end
        return {rs, dr, na, d, 4'(addr)};
    endfunction

    function automatic logic [23:0] stim(input int unsigned cyc);
        if (epoch == 1 && cyc < A_FRAME) return '0;
        if (epoch == 1 && cyc < A_FRAME + A_TL + 2) return 24'hA500FF;
        return 24'($urandom);
    endfunction

    task automatic step(input logic rst_next);
        logic [23:0] v;
        logic [7:0]  pa, pb;
        @(negedge clk);
        pa = {rs_a, dr_a, na_a, do_a, 1'b0, addr_a};
        pb = {rs_b, dr_b, na_b, do_b, 3'b000, addr_b};
        if (reset) begin
            check("rst_A", pa, RST_TUPLE);
            check("rst_B", pb, RST_TUPLE);
            hi_run = 0;
        end else begin
            check($sformatf("A c=%0d", c), pa, ref_out(c, A_N, A_T0, A_T1, A_TB, A_TL));
            check($sformatf("B c=%0d", c), pb, ref_out(c, B_N, B_T0, B_T1, B_TB, B_TL));
            if (do_a) hi_run++;
            else if (hi_run > 0) begin
                if (epoch == 1) pulses.push_back(hi_run);
                hi_run = 0;
            end
            if (!rs_prev && rs_a) rises.push_back(gc);
            if (dr_a && first_dr < 0) first_dr = int'(c);
        end
        rs_prev = rs_a;
        v = reset ? stim(0) : stim(c);
        {green_in, red_in, blue_in} = v;
        if (!rst_next) begin
            if (reset) c = 0;
            hist[c] = v;
            c++;
        end
        reset = rst_next;
        gc++;
    endtask

    initial begin
        logic [23:0] pat;
        pat = 24'hA500FF;

        repeat (3) step(1'b1);
        step(1'b0);
        while (c < C_RST) step(1'b0);

        // Cycle C_RST lies in the high phase of LED3 bit 10 (frame 2).
        check("mid_send_hi", {31'd0, do_a}, 32'd1);
        check("mid_send_addr", {29'd0, addr_a}, 32'd4);
        step(1'b1);
        epoch = 2;
        step(1'b1);
        step(1'b1);
        first_dr = -1;
        step(1'b0);
        while (c < A_TL + 100) step(1'b0);
        check("dr_after_reset", first_dr, A_TL);

        check("rise_count", rises.size(), 2);
        if (rises.size() >= 2)
            check("frame_period", rises[1] - rises[0], A_FRAME);

        check("pulse_count_ge", {31'd0, pulses.size() >= 216}, 32'd1);
        if (pulses.size() >= 216) begin
            for (int i = 0; i < 192; i++)
                check($sformatf("idle_hi[%0d]", i), pulses[i], A_T0);
            for (int i = 0; i < 24; i++)
                check($sformatf("grb_hi[%0d]", i), pulses[192 + i], pat[23 - i] ? A_T1 : A_T0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
